sequence_store: RTL

//  Parametrised register bank for sequence storage: DEPTH entries of WIDTH bits.

---
 rtl/sequence_store.sv | 116 +++++++++++
 1 files changed

// File: rtl/sequence_store.sv
// Register bank of DEPTH entries x WIDTH bits with append-only writes and in-order playback.
// Holds the colour sequence for the Simon game controller.
module sequence_store #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               append_valid,
    input  logic [WIDTH-1:0]   append_data,
    output logic               append_ready,
    input  logic               play_start,
    input  logic               play_step,
    output logic               play_valid,
    output logic [WIDTH-1:0]   play_data,
    output logic               play_last,
    output logic               play_done,
    output logic [PTR_W:0]     length,
    output logic               full,
    output logic               empty
);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LEN_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_length;
    logic [PTR_W:0]   r_playLen;
    logic [PTR_W-1:0] r_index;
    logic             r_playValid;
    logic             r_playDone;
    logic [WIDTH-1:0] r_playData;

    logic w_full;
    logic w_appendFire;
    logic w_lastIdx;

    assign w_full       = (r_length == DEPTH_L);
    assign append_ready = (r_state == IDLE) && !w_full;
    assign w_appendFire = append_valid && append_ready;
    assign w_lastIdx    = ({1'b0, r_index} == (r_playLen - LEN_ONE));

    assign play_valid = r_playValid;
    assign play_data  = r_playData;
    assign play_last  = r_playValid && w_lastIdx;
    assign play_done  = r_playDone;
    assign length     = r_length;
    assign full       = w_full;
    assign empty      = (r_length == '0);

    // Storage has no reset; a write only lands when neither reset nor clear wins the cycle.
    always_ff @(posedge clk) begin
        if (!reset && !clear && w_appendFire) begin
            r_mem[r_length[PTR_W-1:0]] <= append_data;
        end
    end

    // play_len is captured from the pre-append length, so a same-cycle append is not replayed.
    always_ff @(posedge clk) begin
        r_playDone <= 1'b0;
        if (reset) begin
            r_state     <= IDLE;
            r_length    <= '0;
            r_playLen   <= '0;
            r_index     <= '0;
            r_playValid <= 1'b0;
            r_playData  <= '0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_length    <= '0;
            r_index     <= '0;
            r_playValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (play_start) begin
                        if (r_length != '0) begin
                            r_state     <= PLAY;
                            r_playLen   <= r_length;
                            r_index     <= '0;
                            r_playValid <= 1'b1;
                            r_playData  <= r_mem[0];
                        end else begin
                            r_playDone <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (play_step) begin
                        if (w_lastIdx) begin
                            r_state     <= IDLE;
                            r_playValid <= 1'b0;
                            r_playDone  <= 1'b1;
                        end else begin
                            r_index    <= r_index + IDX_ONE;
                            r_playData <= r_mem[r_index + IDX_ONE];
                        end
                    end
                end
            endcase
            if (w_appendFire) begin
                r_length <= r_length + LEN_ONE;
            end
        end
    end

endmodule
